input_panel: RTL and testbench
==============================

Name: input_panel

Overview:
- Front-panel input controller; converts five push-button levels (Left, Right, Up, Down, Enter) into a committed one-hot motor selection and a three-digit BCD target value.
- Synchronizes and edge-detects each button, so one press causes exactly one action.
- A 2-bit cursor selects the edited field: the motor selection or one of three decimal digits.
- Feeds the downstream motor driver and the display/compare logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per button input (minimum 2).

Ports:
- sysclk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Left  in  1  button level; move cursor left (decrement Num).
- Right  in  1  button level; move cursor right (increment Num).
- Up  in  1  button level; increment/rotate the selected field.
- Down  in  1  button level; decrement/rotate the selected field.
- Enter  in  1  button level; commit the pending motor selection.
- TValue0  out  4  BCD ones digit, 0..9.
- TValue1  out  4  BCD tens digit, 0..9.
- TValue2  out  4  BCD hundreds digit, 0..9.
- Motor  out  6  committed motor selection; zero or one-hot.

Behaviour:
- Reset (rst=0, asynchronous) sets all of the following immediately:
  - Motor=000000, MotorCache=000001, Num=00.
  - TValue0=TValue1=TValue2=0.
  - All synchronizer and edge flops cleared.
- Internal state:
  - MotorCache[5:0], the pending one-hot selection.
  - Num[1:0], the cursor: 00 = motor field, 01 = TValue0, 10 = TValue1, 11 = TValue2.
- Input conditioning:
  - Each button passes through SYNC_STAGES flops plus one history flop.
  - A press pulse is generated when the last sync stage is 1 and the history flop is 0.
  - With SYNC_STAGES=2, a button first sampled high at edge k updates state at edge k+2.
  - Holding a button produces one action only; release produces no action.
  - A button already high when rst deasserts counts as one press.
- Actions, one per clock. Priority when several pulses coincide: Enter > Left > Right > Up > Down; lower-priority pulses in that cycle are discarded.
- Enter: Motor <= MotorCache, regardless of Num. Num, MotorCache and digits are unchanged.
- Left: Num <= Num-1 mod 4 (00 -> 11 -> 10 -> 01 -> 00).
- Right: Num <= Num+1 mod 4.
- Up, when Num=00: MotorCache rotates left (000001 -> 000010 ... 100000 -> 000001).
- Up, when Num≠00: the selected digit increments, wrapping 9 -> 0.
- Down, when Num=00: MotorCache rotates right (000001 -> 100000 -> 010000 ...).
- Down, when Num≠00: the selected digit decrements, wrapping 0 -> 9.
- Invariants:
  - Digits never leave 0..9.
  - MotorCache is always exactly one-hot.
  - Motor is 000000 until the first Enter, and one-hot afterwards.
- Motor does not follow MotorCache changes until the next Enter.
- Reset mid-operation returns everything to reset values; an in-flight press is lost.

Test Plan:
- Reset: assert rst=0 for 100 ns then release -> Motor=000000, TValue0/1/2=0; internal MotorCache=000001, Num=00.
- Motor rotate: after reset, press Down twice (100 ns high, 100 ns low each) -> MotorCache 100000 then 010000; Motor stays 000000. Press Up once -> MotorCache=100000.
- Digit edit: from MotorCache=010000, press Left (Num=11), then Down twice -> TValue2=9 then 8. Repeat with Left (Num=10) for TValue1 and Left (Num=01) for TValue0 -> TValue1=8, TValue0=8. Then Enter -> Motor=010000, digits unchanged.
- Wrap and cursor: with Num=01, press Up so TValue0 goes 8 -> 9 -> 0. Press Right from Num=11 -> Num=00. Press Up at Num=00 -> MotorCache rotates left.
- Hold and simultaneous: hold Down for 50 cycles -> exactly one decrement. Raise Enter and Down on the same cycle -> only Motor<=MotorCache; no digit or cache change.
- Async reset mid-edit: pulse rst low between clock edges while Down is held -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/input_panel.sv
`default_nettype none
// ============================================================================
// Module   : input_panel
// Brief    : Five-button front-panel controller producing a committed one-hot
//            motor selection and a three-digit BCD target value.
// Revision : 1.0 - initial release
// ============================================================================
module input_panel #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       Left,
  input  logic       Right,
  input  logic       Up,
  input  logic       Down,
  input  logic       Enter,
  output logic [3:0] TValue0,
  output logic [3:0] TValue1,
  output logic [3:0] TValue2,
  output logic [5:0] Motor
);

  localparam int c_NBTN  = 5;
  localparam int c_ENTER = 4;
  localparam int c_LEFT  = 3;
  localparam int c_RIGHT = 2;
  localparam int c_UP    = 1;
  localparam int c_DOWN  = 0;

  localparam logic [1:0] c_NUM_MOTOR = 2'd0;
  localparam logic [1:0] c_NUM_ONES  = 2'd1;
  localparam logic [1:0] c_NUM_TENS  = 2'd2;
  localparam logic [1:0] c_NUM_HUND  = 2'd3;

  logic [c_NBTN-1:0]             w_btn;
  logic [SYNC_STAGES*c_NBTN-1:0] r_sync;
  logic [c_NBTN-1:0]             r_hist;
  logic [c_NBTN-1:0]             w_last;
  logic [c_NBTN-1:0]             w_press;

  logic [5:0] r_motor, w_motor_nxt;
  logic [5:0] r_cache, w_cache_nxt;
  logic [1:0] r_num,   w_num_nxt;
  logic [3:0] r_d0,    w_d0_nxt;
  logic [3:0] r_d1,    w_d1_nxt;
  logic [3:0] r_d2,    w_d2_nxt;
  logic [3:0] w_cur;
  logic [3:0] w_cur_nxt;
  logic       w_dig_we;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  assign w_btn = {Enter, Left, Right, Up, Down};

  // Stage 0 occupies the low slice; the oldest sample sits at the top.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_sync <= {r_sync[(SYNC_STAGES-1)*c_NBTN-1:0], w_btn};
      r_hist <= w_last;
    end
  end

  assign w_last  = r_sync[SYNC_STAGES*c_NBTN-1 -: c_NBTN];
  assign w_press = w_last & ~r_hist;

  // State register
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      r_motor <= 6'b000000;
      r_cache <= 6'b000001;
      r_num   <= c_NUM_MOTOR;
      r_d0    <= 4'd0;
      r_d1    <= 4'd0;
      r_d2    <= 4'd0;
    end else begin
      r_motor <= w_motor_nxt;
      r_cache <= w_cache_nxt;
      r_num   <= w_num_nxt;
      r_d0    <= w_d0_nxt;
      r_d1    <= w_d1_nxt;
      r_d2    <= w_d2_nxt;
    end
  end

  always_comb begin
    w_cur = 4'd0;
    case (r_num)
      c_NUM_ONES: w_cur = r_d0;
      c_NUM_TENS: w_cur = r_d1;
      c_NUM_HUND: w_cur = r_d2;
      default:    w_cur = 4'd0;
    endcase
  end

  // Single action per clock, highest-priority pulse wins.
  always_comb begin
    w_motor_nxt = r_motor;
    w_cache_nxt = r_cache;
    w_num_nxt   = r_num;
    w_cur_nxt   = w_cur;
    w_dig_we    = 1'b0;
    if (w_press[c_ENTER]) begin
      w_motor_nxt = r_cache;
    end else if (w_press[c_LEFT]) begin
      w_num_nxt = r_num - 2'd1;
    end else if (w_press[c_RIGHT]) begin
      w_num_nxt = r_num + 2'd1;
    end else if (w_press[c_UP]) begin
      if (r_num == c_NUM_MOTOR) begin
        w_cache_nxt = {r_cache[4:0], r_cache[5]};
      end else begin
        w_cur_nxt = bcd_inc(w_cur);
        w_dig_we  = 1'b1;
      end
    end else if (w_press[c_DOWN]) begin
      if (r_num == c_NUM_MOTOR) begin
        w_cache_nxt = {r_cache[0], r_cache[5:1]};
      end else begin
        w_cur_nxt = bcd_dec(w_cur);
        w_dig_we  = 1'b1;
      end
    end
  end

  always_comb begin
    w_d0_nxt = r_d0;
    w_d1_nxt = r_d1;
    w_d2_nxt = r_d2;
    if (w_dig_we) begin
      case (r_num)
        c_NUM_ONES: w_d0_nxt = w_cur_nxt;
        c_NUM_TENS: w_d1_nxt = w_cur_nxt;
        c_NUM_HUND: w_d2_nxt = w_cur_nxt;
        default:    w_d0_nxt = r_d0;
      endcase
    end
  end

  // Outputs
  assign Motor   = r_motor;
  assign TValue0 = r_d0;
  assign TValue1 = r_d1;
  assign TValue2 = r_d2;

endmodule
`default_nettype wire

// File: tb/tb_input_panel.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_panel
// Brief    : Directed scoreboard bench for input_panel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_panel;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b0;
  logic       Left   = 1'b0;
  logic       Right  = 1'b0;
  logic       Up     = 1'b0;
  logic       Down   = 1'b0;
  logic       Enter  = 1'b0;
  logic [3:0] TValue0, TValue1, TValue2;
  logic [5:0] Motor;

  int total = 0;
  int bad   = 0;

  logic [17:0] q_exp[$];
  string       q_name[$];

  localparam logic [4:0] c_E = 5'b10000;
  localparam logic [4:0] c_L = 5'b01000;
  localparam logic [4:0] c_R = 5'b00100;
  localparam logic [4:0] c_U = 5'b00010;
  localparam logic [4:0] c_D = 5'b00001;

  input_panel #(.SYNC_STAGES(2)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .Left   (Left),
    .Right  (Right),
    .Up     (Up),
    .Down   (Down),
    .Enter  (Enter),
    .TValue0(TValue0),
    .TValue1(TValue1),
    .TValue2(TValue2),
    .Motor  (Motor)
  );

  always #5 sysclk = ~sysclk;

  // Monitor: pop and compare away from the active edge.
  always @(negedge sysclk) begin
    if (q_exp.size() > 0) begin
      logic [17:0] e;
      logic [17:0] a;
      string       n;
      e = q_exp.pop_front();
      n = q_name.pop_front();
      a = {Motor, TValue2, TValue1, TValue0};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got motor=%b d=%h%h%h, expected motor=%b d=%h%h%h",
                 n, a[17:12], a[11:8], a[7:4], a[3:0],
                 e[17:12], e[11:8], e[7:4], e[3:0]);
      end
    end
  end

  task automatic expect_out(input logic [5:0] m, input logic [3:0] t2,
                            input logic [3:0] t1, input logic [3:0] t0,
                            input string name);
    q_exp.push_back({m, t2, t1, t0});
    q_name.push_back(name);
  endtask

  task automatic drive(input logic [4:0] mask);
    {Enter, Left, Right, Up, Down} = mask;
  endtask

  // Press for 'hold' cycles, release, settle, then queue the expectation.
  task automatic step(input logic [4:0] mask, input int hold,
                      input logic [5:0] m, input logic [3:0] t2,
                      input logic [3:0] t1, input logic [3:0] t0,
                      input string name);
    @(posedge sysclk); #1;
    drive(mask);
    repeat (hold) @(posedge sysclk);
    #1 drive(5'b0);
    repeat (10) @(posedge sysclk);
    #1 expect_out(m, t2, t1, t0, name);
  endtask

  initial begin
    rst = 1'b0;
    #100;
    rst = 1'b1;
    @(posedge sysclk); #1;
    expect_out(6'b000000, 4'd0, 4'd0, 4'd0, "reset");

    // Motor field rotation; Motor stays cleared until Enter
    step(c_D, 10, 6'b000000, 4'd0, 4'd0, 4'd0, "down1");
    step(c_D, 10, 6'b000000, 4'd0, 4'd0, 4'd0, "down2");
    step(c_E, 10, 6'b010000, 4'd0, 4'd0, 4'd0, "enter1");
    step(c_U, 10, 6'b010000, 4'd0, 4'd0, 4'd0, "up_cache");
    step(c_D, 10, 6'b010000, 4'd0, 4'd0, 4'd0, "down3");

    // Digit editing, wrap 0 -> 9 downward
    step(c_L, 10, 6'b010000, 4'd0, 4'd0, 4'd0, "left_to3");
    step(c_D, 10, 6'b010000, 4'd9, 4'd0, 4'd0, "t2_9");
    step(c_D, 10, 6'b010000, 4'd8, 4'd0, 4'd0, "t2_8");
    step(c_L, 10, 6'b010000, 4'd8, 4'd0, 4'd0, "left_to2");
    step(c_D, 10, 6'b010000, 4'd8, 4'd9, 4'd0, "t1_9");
    step(c_D, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "t1_8");
    step(c_L, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "left_to1");
    step(c_D, 10, 6'b010000, 4'd8, 4'd8, 4'd9, "t0_9");
    step(c_D, 10, 6'b010000, 4'd8, 4'd8, 4'd8, "t0_8");

    // Upward wrap 9 -> 0, then cursor wrap 11 -> 00
    step(c_U, 10, 6'b010000, 4'd8, 4'd8, 4'd9, "t0_up9");
    step(c_U, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "t0_wrap0");
    step(c_R, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "right_to2");
    step(c_R, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "right_to3");
    step(c_R, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "right_to0");
    step(c_U, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "up_rotl");
    step(c_E, 10, 6'b100000, 4'd8, 4'd8, 4'd0, "enter_rotl");

    // Long hold gives a single step: cache 100000 -> 010000
    step(c_D, 50, 6'b100000, 4'd8, 4'd8, 4'd0, "hold50");
    step(c_E, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "enter_hold");

    // Enter beats Down; a dropped Down leaves cache at 010000
    step(c_E | c_D, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "enter_down");
    step(c_D, 10, 6'b010000, 4'd8, 4'd8, 4'd0, "down_after");
    step(c_E, 10, 6'b001000, 4'd8, 4'd8, 4'd0, "enter_after");

    // Left beats Right and Up
    step(c_L | c_R | c_U, 10, 6'b001000, 4'd8, 4'd8, 4'd0, "left_prio");
    step(c_D, 10, 6'b001000, 4'd7, 4'd8, 4'd0, "t2_7");
    step(c_R, 10, 6'b001000, 4'd7, 4'd8, 4'd0, "right_to0b");

    // Asynchronous reset between edges while Down is held
    @(posedge sysclk); #1;
    Down = 1'b1;
    @(posedge sysclk); #2;
    rst = 1'b0;
    #1 expect_out(6'b000000, 4'd0, 4'd0, 4'd0, "async_rst");
    @(posedge sysclk); #1;
    rst = 1'b1;
    repeat (6) @(posedge sysclk);
    #1 Down = 1'b0;
    repeat (4) @(posedge sysclk);
    #1 expect_out(6'b000000, 4'd0, 4'd0, 4'd0, "post_rst");
    step(c_E, 10, 6'b100000, 4'd0, 4'd0, 4'd0, "held_press");

    begin : drain
      int n;
      n = 0;
      while (q_exp.size() > 0 && n < 100) begin
        @(posedge sysclk);
        n++;
      end
      if (q_exp.size() > 0) begin
        bad++;
        $display("FAIL drain: %0d checks pending, expected 0", q_exp.size());
      end
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
